// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b, LSB first, one bit per clock).
// Define SERIAL_SUBTRACTOR_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_n;
   logic [CW-1:0]    cnt;
   logic             br, br_n, d, load, last;

   assign busy = (state == RUN);
   assign done = (state == DONE);
   // Operands are accepted in IDLE and also in DONE for back-to-back use.
   assign load = start && (state != RUN);
   assign last = (state == RUN) && (cnt == LAST);

   always_comb begin
      d     = a_sr[0] ^ b_sr[0] ^ br;
      br_n  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
      res_n = {d, res_sr[WIDTH-1:1]};
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = RUN;
         RUN:     if (cnt == LAST) state_n = DONE;
         DONE:    state_n = start ? RUN : IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         cnt    <= '0;
         br     <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
      end else if (load) begin
         a_sr   <= a;
         b_sr   <= b;
         res_sr <= '0;
         cnt    <= '0;
         br     <= 1'b0;
      end else if (state == RUN) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         res_sr <= res_n;
         cnt    <= cnt + 1'b1;
         br     <= br_n;
         if (last) begin
            diff   <= res_n;
            borrow <= br_n;
         end
      end
   end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic a_msb, b_msb;

   // The result MSB is the bit produced on the final step, i.e. d.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf   <= 1'b0;
      end else if (load) begin
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
      end else if (last) begin
         ovf <= (a_msb != b_msb) && (d != a_msb);
      end
   end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_subtractor;
   localparam int WIDTH = 8;

   typedef struct packed {
      logic [WIDTH-1:0] d;
      logic             br;
      logic             ov;
   } exp_t;

   logic             clk, rst_n, start;
   logic [WIDTH-1:0] a, b, diff;
   logic             busy, done, borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic             ovf;
`endif

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .diff(diff), .borrow(borrow)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      , .ovf(ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   nvec = 0, nerr = 0, busy_cnt = 0;
   bit   fin = 0, fin_chk = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         nvec++;
         if (busy || done || diff != '0 || borrow
`ifdef SERIAL_SUBTRACTOR_OVF_EN
             || ovf
`endif
            ) begin
            nerr++;
            $display("FAIL reset_state: busy=%b done=%b diff=%h borrow=%b, want all 0",
                     busy, done, diff, borrow);
         end
         busy_cnt = 0;
      end else begin
         if (busy) busy_cnt++;
         if (done) begin
            nvec++;
            if (busy_cnt != WIDTH) begin
               nerr++;
               $display("FAIL busy_len: got %0d busy cycles before done, want %0d", busy_cnt, WIDTH);
            end
            busy_cnt = 0;
            nvec++;
            if (exp_q.size() == 0) begin
               nerr++;
               $display("FAIL unexpected_done: diff=%h borrow=%b, want no done", diff, borrow);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (diff != e.d || borrow != e.br) begin
                  nerr++;
                  $display("FAIL result: diff=%h borrow=%b, want diff=%h borrow=%b",
                           diff, borrow, e.d, e.br);
               end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
               nvec++;
               if (ovf != e.ov) begin
                  nerr++;
                  $display("FAIL ovf: got %b want %b (diff=%h)", ovf, e.ov, e.d);
               end
`endif
            end
         end
         if (fin && !fin_chk) begin
            fin_chk = 1;
            nvec++;
            if (exp_q.size() != 0) begin
               nerr++;
               $display("FAIL missing_done: %0d results outstanding, want 0", exp_q.size());
            end
         end
      end
   end

   task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input bit push, input exp_t e);
      start = 1'b1;
      a     = ta;
      b     = tb;
      if (push) exp_q.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 4 * WIDTH; i++) begin
         if (done) return;
         @(posedge clk); #1;
      end
      $display("FAIL timeout: done not seen within %0d cycles", 4 * WIDTH);
      $fatal(1, "done timeout");
   endtask

   task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input exp_t e);
      issue(ta, tb, 1, e);
      wait_done();
      repeat (2) begin @(posedge clk); #1; end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(8'h05, 8'h03, '{8'h02, 1'b0, 1'b0});
      run_op(8'h03, 8'h05, '{8'hFE, 1'b1, 1'b0});
      run_op(8'h00, 8'h00, '{8'h00, 1'b0, 1'b0});
      run_op(8'hFF, 8'h01, '{8'hFE, 1'b0, 1'b0});

      // Start while busy is ignored, then a start in the DONE cycle chains.
      issue(8'h10, 8'h01, 1, '{8'h0F, 1'b0, 1'b0});
      repeat (2) begin @(posedge clk); #1; end
      issue(8'h00, 8'h01, 0, '{8'h00, 1'b0, 1'b0});
      wait_done();
      issue(8'h00, 8'h01, 1, '{8'hFF, 1'b1, 1'b0});
      wait_done();
      repeat (2) begin @(posedge clk); #1; end

      // Abort mid-run with an asynchronous reset; no done may follow.
      issue(8'h55, 8'h22, 0, '{8'h00, 1'b0, 1'b0});
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      run_op(8'h55, 8'h22, '{8'h33, 1'b0, 1'b0});

      run_op(8'h80, 8'h01, '{8'h7F, 1'b0, 1'b1});
      run_op(8'h7F, 8'h01, '{8'h7E, 1'b0, 1'b0});
      run_op(8'h7F, 8'hFF, '{8'h80, 1'b1, 1'b1});

      repeat (WIDTH + 4) begin @(posedge clk); #1; end
      fin = 1;
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor. Computes a - b LSB-first, one bit per clock, using a single full-subtractor cell and a registered borrow.
- This is the inverse-operation counterpart of the team's combinational adder cells.
- Used where area matters more than latency. Operands are loaded through a start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only when busy is low.
- a  input  WIDTH  minuend; sampled in the start cycle.
- b  input  WIDTH  subtrahend; sampled in the start cycle.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  single-cycle pulse; diff and borrow are valid.
- diff  output  WIDTH  result a - b modulo 2^WIDTH.
- borrow  output  1  high when unsigned a < b.
- ovf  output  1  signed overflow; present only with the optional feature.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - busy = 0, done = 0, diff = 0, borrow = 0, ovf = 0.
  - Internal shift registers, bit counter and borrow register = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On a clock edge with start = 1: load a and b into shift registers, clear the counter and borrow register, go to RUN.
  - start = 0: stay in IDLE.
- RUN, one step per edge:
  - d = a0 ^ b0 ^ br.
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - Shift d into the MSB of the internal result register; shift both operand registers right by 1; increment the counter.
  - On the WIDTH-th step, go to DONE. At the same edge, diff <= the full internal result and borrow <= br_next.
- DONE:
  - Held for exactly one cycle, then go to IDLE.
  - If start = 1 in the DONE cycle, the new operands are accepted and the next state is RUN (back-to-back operation).
- busy = 1 in RUN only. done = 1 in DONE only. Both are decoded directly from registered state.
- Latency: start sampled at edge E0. Result bits are computed at edges E1..E_WIDTH. done is high from after E_WIDTH until E_WIDTH+1.
- Throughput: one result per WIDTH+1 cycles.
- diff and borrow change only on the RUN->DONE edge. They hold their last value through IDLE and through the next RUN.
- start while busy = 1 is ignored. The a and b inputs may change freely after the start cycle.
- Reset asserted mid-RUN aborts the operation immediately:
  - No done pulse is produced.
  - Outputs return to their reset values.
- The counter width is clog2(WIDTH)+1 bits, so the count never wraps before WIDTH is reached.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- When defined:
  - The ovf port exists.
  - ovf is registered on the RUN->DONE edge as (a_msb != b_msb) && (diff_msb != a_msb), using the operand MSBs captured at start.
  - ovf holds its value like diff.
  - Reset value is 0.
- When undefined:
  - The ovf port is absent.
  - No MSB capture logic is present.
  - All other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, start pulse -> busy high for 8 cycles, done pulse on cycle 9, diff=0x02, borrow=0.
- a=0x03, b=0x05 -> diff=0xFE, borrow=1.
- Edge operands, run separately:
  - a=0x00, b=0x00 -> diff=0x00, borrow=0.
  - a=0xFF, b=0x01 -> diff=0xFE, borrow=0.
- Start 0x10-0x01, then pulse start with 0x00-0x01 at cycle 3 -> second start ignored; result 0x0F. Then start asserted during the done cycle with 0x00-0x01 -> accepted back-to-back, diff=0xFF, borrow=1.
- Start 0x55-0x22; drop rst_n at cycle 4 -> outputs 0 immediately, no done pulse. After release, a new start for 0x55-0x22 yields diff=0x33.
- With SERIAL_SUBTRACTOR_OVF_EN defined:
  - a=0x80, b=0x01 -> diff=0x7F, ovf=1.
  - a=0x7F, b=0x01 -> diff=0x7E, ovf=0.
  - a=0x7F, b=0xFF -> diff=0x80, ovf=1.
